// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
// bridge_pkg: shared types and constants for the dev_bridge peripheral-bus initiator. Rev 1.0
// ============================================================================
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int SLOT_BYTES  = 16;
  localparam int HWINT_W     = 6;
  localparam int WORD_SEL_HI = 3;
  localparam int WORD_SEL_LO = 2;
  // Wide enough for slots 0..5 plus the extra control slot index.
  localparam int SEL_W       = 3;

endpackage
`default_nettype wire

// File: rtl/bridge_decode.sv
`default_nettype none
// ============================================================================
// bridge_decode: combinational address decode into device slot, control slot and alignment flags. Rev 1.0
// ============================================================================
module bridge_decode
  import bridge_pkg::*;
#(
  parameter int          NDEV = 2,
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             misaligned_o,
  output logic             ctrl_slot_o
);

  localparam logic [31:0] DEV_SPAN = 32'(SLOT_BYTES * NDEV);
  localparam logic [31:0] CTRL_END = 32'(SLOT_BYTES * (NDEV + 1));

  logic [31:0] w_off;
  logic        w_above;

  // Comparing the offset rather than absolute bounds avoids overflow near the top of memory.
  assign w_off        = addr_i - BASE;
  assign w_above      = (addr_i >= BASE);
  assign hit_o        = w_above && (w_off < DEV_SPAN);
  assign ctrl_slot_o  = w_above && (w_off >= DEV_SPAN) && (w_off < CTRL_END);
  assign misaligned_o = |addr_i[1:0];
  assign sel_o        = w_off[6:4];

endmodule
`default_nettype wire

// File: rtl/dev_bridge.sv
`default_nettype none
// ============================================================================
// dev_bridge: CPU load/store initiator for timer-class peripherals with IRQ collection.
// IRQ_STICKY_EN adds sticky pending bits and a W1C control slot after the last device. Rev 1.0
// ============================================================================
module dev_bridge
  import bridge_pkg::*;
#(
  parameter int          NDEV = 2,
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ready,
  output logic                 cpu_err,
  output logic [1:0]           pr_addr,
  output logic [31:0]          pr_wdata,
  output logic [NDEV-1:0]      pr_we,
  input  logic [32*NDEV-1:0]   pr_rdata,
  input  logic [NDEV-1:0]      dev_irq,
  output logic [HWINT_W-1:0]   hw_int
);

  state_e           state_q;
  logic             we_q;
  logic             ctrl_q;
  logic [SEL_W-1:0] sel_q;
  logic [31:0]      rdata_q;
  logic             ready_q;
  logic             err_q;
  logic [1:0]       pr_addr_q;
  logic [31:0]      pr_wdata_q;
  logic [NDEV-1:0]  pr_we_q;

  logic             w_hit;
  logic             w_ctrl_slot;
  logic             w_misaligned;
  logic [SEL_W-1:0] w_sel;
  logic             w_ctrl_ok;
  logic             w_accept;
  logic [NDEV-1:0]  w_sel_onehot;
  logic [31:0]      w_dev_rdata;
  logic [31:0]      w_ctrl_rdata;

  bridge_decode #(
    .NDEV (NDEV),
    .BASE (BASE)
  ) u_decode (
    .addr_i       (cpu_addr),
    .hit_o        (w_hit),
    .sel_o        (w_sel),
    .misaligned_o (w_misaligned),
    .ctrl_slot_o  (w_ctrl_slot)
  );

`ifdef IRQ_STICKY_EN
  assign w_ctrl_ok = w_ctrl_slot && (cpu_addr[WORD_SEL_HI:WORD_SEL_LO] == 2'd0);
`else
  logic w_unused_ctrl;
  assign w_ctrl_ok     = 1'b0;
  assign w_unused_ctrl = w_ctrl_slot;
`endif

  assign w_accept = (w_hit || w_ctrl_ok) && !w_misaligned;

  always_comb begin
    w_sel_onehot = '0;
    w_dev_rdata  = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (w_sel == SEL_W'(i)) w_sel_onehot[i] = 1'b1;
      if (sel_q == SEL_W'(i)) w_dev_rdata = pr_rdata[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      ctrl_q     <= 1'b0;
      sel_q      <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      pr_addr_q  <= '0;
      pr_wdata_q <= '0;
      pr_we_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          pr_we_q <= '0;
          if (cpu_req) begin
            if (w_accept) begin
              state_q    <= ACCESS;
              we_q       <= cpu_we;
              ctrl_q     <= w_ctrl_ok;
              sel_q      <= w_sel;
              pr_addr_q  <= cpu_addr[WORD_SEL_HI:WORD_SEL_LO];
              pr_wdata_q <= cpu_wdata;
              pr_we_q    <= (cpu_we && !w_ctrl_ok) ? w_sel_onehot : '0;
            end else begin
              // Decode errors skip the bus cycle entirely so no strobe can fire.
              state_q <= RESP;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          state_q <= RESP;
          pr_we_q <= '0;
          ready_q <= 1'b1;
          err_q   <= 1'b0;
          rdata_q <= we_q ? 32'd0 : (ctrl_q ? w_ctrl_rdata : w_dev_rdata);
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IRQ_STICKY_EN
  logic [NDEV-1:0]    pending_q;
  logic [NDEV-1:0]    pending_d;
  logic [NDEV-1:0]    w_clr;
  logic [HWINT_W-1:0] w_irq_vec;

  // A new IRQ level in the same cycle as the W1C write keeps its bit set.
  assign w_clr     = (state_q == ACCESS && ctrl_q && we_q) ? pr_wdata_q[NDEV-1:0] : '0;
  assign pending_d = (pending_q & ~w_clr) | dev_irq;

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  always_comb begin
    w_irq_vec    = '0;
    w_ctrl_rdata = '0;
    for (int i = 0; i < NDEV; i++) begin
      w_irq_vec[i]    = pending_q[i];
      w_ctrl_rdata[i] = pending_q[i];
    end
  end

  assign hw_int = w_irq_vec;
`else
  logic [HWINT_W-1:0] hw_int_q;
  logic [HWINT_W-1:0] w_irq_vec;

  always_comb begin
    w_irq_vec = '0;
    for (int i = 0; i < NDEV; i++) w_irq_vec[i] = dev_irq[i];
  end

  always_ff @(posedge clk) begin
    if (reset) hw_int_q <= '0;
    else       hw_int_q <= w_irq_vec;
  end

  assign w_ctrl_rdata = '0;
  assign hw_int       = hw_int_q;
`endif

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign cpu_err   = err_q;
  assign pr_addr   = pr_addr_q;
  assign pr_wdata  = pr_wdata_q;
  assign pr_we     = pr_we_q;

endmodule
`default_nettype wire

// File: tb/tb_dev_bridge.sv
`default_nettype none
// ============================================================================
// tb_dev_bridge: directed plus randomized self-checking bench for dev_bridge (plain and IRQ_STICKY_EN builds). Rev 1.0
// ============================================================================
module tb_dev_bridge;

  localparam int          NDEV = 2;
  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cpu_req;
  logic                 cpu_we;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [31:0]          cpu_rdata;
  logic                 cpu_ready;
  logic                 cpu_err;
  logic [1:0]           pr_addr;
  logic [31:0]          pr_wdata;
  logic [NDEV-1:0]      pr_we;
  logic [32*NDEV-1:0]   pr_rdata;
  logic [NDEV-1:0]      dev_irq;
  logic [5:0]           hw_int;

  int checks   = 0;
  int failures = 0;

  logic            dev_clr;
  logic [31:0]     dev_mem   [NDEV][4];
  logic [31:0]     model_mem [NDEV][4];
  logic [NDEV-1:0] model_pend;

  always #5 clk = ~clk;

  dev_bridge #(.NDEV(NDEV), .BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .pr_addr   (pr_addr),
    .pr_wdata  (pr_wdata),
    .pr_we     (pr_we),
    .pr_rdata  (pr_rdata),
    .dev_irq   (dev_irq),
    .hw_int    (hw_int)
  );

  // Simple register-file devices: combinational read, write on strobe.
  always @(posedge clk) begin
    for (int i = 0; i < NDEV; i++)
      for (int w = 0; w < 4; w++)
        if (dev_clr) dev_mem[i][w] <= '0;
        else if (pr_we[i] && pr_addr == 2'(w)) dev_mem[i][w] <= pr_wdata;
  end

  always_comb begin
    pr_rdata = '0;
    for (int i = 0; i < NDEV; i++) pr_rdata[32*i +: 32] = dev_mem[i][pr_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address map from first principles: device slots, then (sticky build) control word 0.
  function automatic void decode_model(input logic [31:0] a, output bit err,
                                       output bit is_ctrl, output int slot);
    longint off;
    err = 1'b1; is_ctrl = 1'b0; slot = 0;
    if (a[1:0] != 2'd0) return;
    if (a < BASE) return;
    off = longint'(a) - longint'(BASE);
    if (off < 16 * NDEV) begin
      err = 1'b0; slot = int'(off / 16);
    end
`ifdef IRQ_STICKY_EN
    else if (off >= 16 * NDEV && off < 16 * NDEV + 4) begin
      err = 1'b0; is_ctrl = 1'b1;
    end
`endif
  endfunction

  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input bit keep_req, input int extra);
    bit              e_err, e_ctrl, got;
    int              slot, e_lat, cyc, we_cnt;
    logic [NDEV-1:0] e_we, we_or;
    logic [31:0]     e_rd;
    decode_model(a, e_err, e_ctrl, slot);
    e_we = '0;
    e_rd = '0;
    if (!e_err && !e_ctrl && we) e_we[slot] = 1'b1;
    if (!e_err && !we) e_rd = e_ctrl ? 32'(model_pend) : model_mem[slot][a[3:2]];
    e_lat = (e_err ? 1 : 2) + extra;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    cyc = 0; got = 1'b0; we_cnt = 0; we_or = '0;
    while (!got && cyc < 8) begin
      step();
      cyc++;
      if (pr_we != '0) begin
        we_cnt++;
        we_or |= pr_we;
      end
      if (!e_err && cyc == 1 + extra) begin
        chk("access_pr_we", 32'(pr_we), 32'(e_we));
        chk("access_pr_addr", 32'(pr_addr), 32'(a[3:2]));
        chk("access_pr_wdata", pr_wdata, wd);
      end
      if (cpu_ready) got = 1'b1;
    end
    chk("ready_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc), 32'(e_lat));
    chk("resp_err", 32'(cpu_err), 32'(e_err));
    chk("resp_rdata", cpu_rdata, e_rd);
    chk("strobe_count", 32'(we_cnt), (!e_err && !e_ctrl && we) ? 32'd1 : 32'd0);
    chk("strobe_slot", 32'(we_or), 32'(e_we));
    if (!e_err && we) begin
      if (e_ctrl) model_pend &= ~wd[NDEV-1:0];
      else        model_mem[slot][a[3:2]] = wd;
    end
    if (!keep_req) begin
      cpu_req = 1'b0;
      step();
      chk("idle_pr_we", 32'(pr_we), 32'd0);
    end
  endtask

  initial begin
    logic [31:0]     addr, data, expv;
    logic [NDEV-1:0] irq_v;
    bit              keep, prev_keep;

    reset = 1'b1; dev_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; dev_irq = '0;
    model_pend = '0;
    for (int i = 0; i < NDEV; i++) for (int w = 0; w < 4; w++) model_mem[i][w] = '0;
    repeat (3) step();
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_pr_we", 32'(pr_we), 32'd0);
    chk("rst_pr_addr", 32'(pr_addr), 32'd0);
    chk("rst_pr_wdata", pr_wdata, 32'd0);
    chk("rst_hw_int", 32'(hw_int), 32'd0);
    reset = 1'b0; dev_clr = 1'b0;
    step();

    access(1'b1, 32'h0000_7F00, 32'h9, 1'b0, 0);
    access(1'b1, 32'h0000_7F14, 32'hDEAD_BEEF, 1'b0, 0);
    access(1'b0, 32'h0000_7F14, 32'h0, 1'b0, 0);
    access(1'b0, 32'h0000_7F00, 32'h0, 1'b0, 0);
    access(1'b0, 32'h0000_7F40, 32'h0, 1'b0, 0);
    access(1'b1, 32'h0000_7F02, 32'h1234_5678, 1'b0, 0);
    access(1'b1, 32'h0000_7F24, 32'h3, 1'b0, 0);

    dev_irq = 2'b10;
    step();
    chk("irq_pulse_set", 32'(hw_int), 32'h2);
    dev_irq = 2'b00;
`ifdef IRQ_STICKY_EN
    model_pend = 2'b10;
    step();
    chk("irq_sticky_hold", 32'(hw_int), 32'h2);
    step();
    chk("irq_sticky_hold2", 32'(hw_int), 32'h2);
    access(1'b0, BASE + 32'(16 * NDEV), 32'h0, 1'b0, 0);
    access(1'b1, BASE + 32'(16 * NDEV), 32'h2, 1'b0, 0);
    chk("irq_sticky_clear", 32'(hw_int), 32'(model_pend));
`else
    step();
    chk("irq_pulse_clear", 32'(hw_int), 32'h0);
`endif

    for (int k = 0; k < 10; k++) begin
      irq_v = NDEV'($urandom);
      dev_irq = irq_v;
      step();
`ifdef IRQ_STICKY_EN
      model_pend |= irq_v;
      expv = 32'(model_pend);
`else
      expv = 32'(irq_v);
`endif
      chk("irq_rand", 32'(hw_int), expv);
    end
    dev_irq = '0;
    step();

    prev_keep = 1'b0;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0, 1:    addr = BASE + 32'(16 * $urandom_range(0, NDEV - 1)) + 32'(4 * $urandom_range(0, 3));
        2:       addr = BASE + 32'(16 * $urandom_range(0, NDEV - 1)) + 32'($urandom_range(1, 3));
        3:       addr = BASE + 32'(16 * NDEV) + 32'(4 * $urandom_range(0, 3));
        4:       addr = BASE - 32'(4 * $urandom_range(1, 8));
        default: addr = BASE + 32'(16 * NDEV + 16) + 32'(4 * $urandom_range(0, 100));
      endcase
      data = $urandom;
      keep = (k == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      access(1'($urandom_range(0, 1)), addr, data, keep, prev_keep ? 1 : 0);
      prev_keep = keep;
    end

    access(1'b1, 32'h0000_7F04, 32'hAAAA_0001, 1'b1, 0);
    access(1'b1, 32'h0000_7F18, 32'hBBBB_0002, 1'b1, 1);
    access(1'b0, 32'h0000_7F04, 32'h0, 1'b1, 1);
    access(1'b0, 32'h0000_7F18, 32'h0, 1'b0, 1);

    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_7F08; cpu_wdata = 32'hC0FF_EE00;
    step();
    chk("mid_rst_strobe", 32'(pr_we), 32'h1);
    reset = 1'b1; cpu_req = 1'b0;
    step();
    model_mem[0][2] = 32'hC0FF_EE00;
    model_pend = '0;
    chk("mid_rst_ready", 32'(cpu_ready), 32'd0);
    chk("mid_rst_err", 32'(cpu_err), 32'd0);
    chk("mid_rst_rdata", cpu_rdata, 32'd0);
    chk("mid_rst_pr_we", 32'(pr_we), 32'd0);
    chk("mid_rst_pr_addr", 32'(pr_addr), 32'd0);
    chk("mid_rst_pr_wdata", pr_wdata, 32'd0);
    chk("mid_rst_hw_int", 32'(hw_int), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", 32'(cpu_ready), 32'd0);
    access(1'b0, 32'h0000_7F08, 32'h0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
